// File: rtl/rgb_downsampler.sv
// rtl/rgb_downsampler.sv - RGB to planar 4:2:2 YUV encoder reading and writing one shared SRAM port
module rgb_downsampler #(
    parameter logic [17:0] RGB_BASE   = 18'd146944,
    parameter logic [17:0] Y_BASE     = 18'd0,
    parameter logic [17:0] U_BASE     = 18'd38400,
    parameter logic [17:0] V_BASE     = 18'd57600,
    parameter int          NUM_GROUPS = 19200
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    input  logic        enc_start,
    output logic        enc_done
);

    localparam int             GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [GW-1:0]  LAST_GROUP = GW'(NUM_GROUPS - 1);

    // BT.601 coefficients scaled by 65536
    localparam logic signed [31:0] C_YR = 32'sd16843;
    localparam logic signed [31:0] C_YG = 32'sd33030;
    localparam logic signed [31:0] C_YB = 32'sd6423;
    localparam logic signed [31:0] C_UR = -32'sd9699;
    localparam logic signed [31:0] C_UG = -32'sd19071;
    localparam logic signed [31:0] C_UB = 32'sd28770;
    localparam logic signed [31:0] C_VR = 32'sd28770;
    localparam logic signed [31:0] C_VG = -32'sd24117;
    localparam logic signed [31:0] C_VB = -32'sd4653;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5,
        S_WAIT0, S_WAIT1,
        S_CALC0, S_CALC1,
        S_WR_Y0, S_WR_Y1, S_WR_U, S_WR_V,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [17:0]    r_sram_address, w_sram_address;
    logic [15:0]    r_sram_write_data, w_sram_write_data;
    logic           r_sram_we_n, w_sram_we_n;
    logic           r_enc_done, w_enc_done;

    logic [17:0]    r_rgb_addr, w_rgb_addr;
    logic [17:0]    r_y_addr, w_y_addr;
    logic [17:0]    r_u_addr, w_u_addr;
    logic [17:0]    r_v_addr, w_v_addr;
    logic [GW-1:0]  r_group, w_group;

    logic [15:0]    r_word [6];
    logic [7:0]     r_y0, r_y1, r_y2, r_y3;
    logic [7:0]     r_u01, r_u23, r_v01, r_v23;

    logic           w_sel_hi;
    logic [7:0]     w_ra, w_ga, w_ba, w_rb, w_gb, w_bb;
    logic [7:0]     w_r_avg, w_g_avg, w_b_avg;
    logic [7:0]     w_y_a, w_y_b, w_u, w_v;

    // One row of the colour matrix: rounding, arithmetic shift, offset, clip to a byte
    function automatic logic [7:0] f_row(
        input logic [7:0]         i_r,
        input logic [7:0]         i_g,
        input logic [7:0]         i_b,
        input logic signed [31:0] i_cr,
        input logic signed [31:0] i_cg,
        input logic signed [31:0] i_cb,
        input logic signed [31:0] i_off
    );
        logic signed [31:0] v_acc;
        v_acc = i_cr * $signed({24'd0, i_r})
              + i_cg * $signed({24'd0, i_g})
              + i_cb * $signed({24'd0, i_b})
              + 32'sd32768;
        v_acc = (v_acc >>> 16) + i_off;
        if (v_acc < 32'sd0)
            f_row = 8'd0;
        else if (v_acc > 32'sd255)
            f_row = 8'd255;
        else
            f_row = v_acc[7:0];
    endfunction

    // Rounded mean of two bytes through a 9-bit sum
    function automatic logic [7:0] f_avg(input logic [7:0] i_a, input logic [7:0] i_b);
        f_avg = 8'(({1'b0, i_a} + {1'b0, i_b} + 9'd1) >> 1);
    endfunction

    assign SRAM_address    = r_sram_address;
    assign SRAM_write_data = r_sram_write_data;
    assign SRAM_we_n       = r_sram_we_n;
    assign enc_done        = r_enc_done;

    // Shared datapath: CALC0 works on pixels 0/1, CALC1 on pixels 2/3
    assign w_sel_hi = (r_state == S_CALC1);
    assign w_ra = w_sel_hi ? r_word[3][15:8] : r_word[0][15:8];
    assign w_ga = w_sel_hi ? r_word[3][7:0]  : r_word[0][7:0];
    assign w_ba = w_sel_hi ? r_word[4][15:8] : r_word[1][15:8];
    assign w_rb = w_sel_hi ? r_word[4][7:0]  : r_word[1][7:0];
    assign w_gb = w_sel_hi ? r_word[5][15:8] : r_word[2][15:8];
    assign w_bb = w_sel_hi ? r_word[5][7:0]  : r_word[2][7:0];

    assign w_r_avg = f_avg(w_ra, w_rb);
    assign w_g_avg = f_avg(w_ga, w_gb);
    assign w_b_avg = f_avg(w_ba, w_bb);

    assign w_y_a = f_row(w_ra, w_ga, w_ba, C_YR, C_YG, C_YB, 32'sd16);
    assign w_y_b = f_row(w_rb, w_gb, w_bb, C_YR, C_YG, C_YB, 32'sd16);
    assign w_u   = f_row(w_r_avg, w_g_avg, w_b_avg, C_UR, C_UG, C_UB, 32'sd128);
    assign w_v   = f_row(w_r_avg, w_g_avg, w_b_avg, C_VR, C_VG, C_VB, 32'sd128);

    // State register
    always_ff @(posedge CLOCK_50_I) begin
        if (!Resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next state plus the port values and counters that take effect on entering it
    always_comb begin
        w_next_state      = r_state;
        w_sram_address    = r_sram_address;
        w_sram_write_data = r_sram_write_data;
        w_sram_we_n       = 1'b1;
        w_enc_done        = 1'b0;
        w_rgb_addr        = r_rgb_addr;
        w_y_addr          = r_y_addr;
        w_u_addr          = r_u_addr;
        w_v_addr          = r_v_addr;
        w_group           = r_group;
        case (r_state)
            S_IDLE: begin
                if (enc_start) begin
                    w_next_state   = S_RD0;
                    w_sram_address = r_rgb_addr;
                end
            end
            S_RD0: begin
                w_next_state   = S_RD1;
                w_sram_address = r_rgb_addr + 18'd1;
            end
            S_RD1: begin
                w_next_state   = S_RD2;
                w_sram_address = r_rgb_addr + 18'd2;
            end
            S_RD2: begin
                w_next_state   = S_RD3;
                w_sram_address = r_rgb_addr + 18'd3;
            end
            S_RD3: begin
                w_next_state   = S_RD4;
                w_sram_address = r_rgb_addr + 18'd4;
            end
            S_RD4: begin
                w_next_state   = S_RD5;
                w_sram_address = r_rgb_addr + 18'd5;
            end
            S_RD5: begin
                w_next_state = S_WAIT0;
                w_rgb_addr   = r_rgb_addr + 18'd6;
            end
            S_WAIT0: w_next_state = S_WAIT1;
            S_WAIT1: w_next_state = S_CALC0;
            S_CALC0: w_next_state = S_CALC1;
            S_CALC1: begin
                w_next_state      = S_WR_Y0;
                w_sram_address    = r_y_addr;
                w_sram_write_data = {r_y0, r_y1};
                w_sram_we_n       = 1'b0;
            end
            S_WR_Y0: begin
                w_next_state      = S_WR_Y1;
                w_sram_address    = r_y_addr + 18'd1;
                w_sram_write_data = {r_y2, r_y3};
                w_sram_we_n       = 1'b0;
                w_y_addr          = r_y_addr + 18'd2;
            end
            S_WR_Y1: begin
                w_next_state      = S_WR_U;
                w_sram_address    = r_u_addr;
                w_sram_write_data = {r_u01, r_u23};
                w_sram_we_n       = 1'b0;
                w_u_addr          = r_u_addr + 18'd1;
            end
            S_WR_U: begin
                w_next_state      = S_WR_V;
                w_sram_address    = r_v_addr;
                w_sram_write_data = {r_v01, r_v23};
                w_sram_we_n       = 1'b0;
                w_v_addr          = r_v_addr + 18'd1;
            end
            S_WR_V: begin
                if (r_group == LAST_GROUP) begin
                    w_next_state = S_DONE;
                    w_enc_done   = 1'b1;
                end else begin
                    w_next_state   = S_RD0;
                    w_sram_address = r_rgb_addr;
                    w_group        = r_group + 1'b1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                w_rgb_addr   = RGB_BASE;
                w_y_addr     = Y_BASE;
                w_u_addr     = U_BASE;
                w_v_addr     = V_BASE;
                w_group      = '0;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Registered SRAM port, done pulse and address counters
    always_ff @(posedge CLOCK_50_I) begin
        if (!Resetn) begin
            r_sram_address    <= 18'd0;
            r_sram_write_data <= 16'd0;
            r_sram_we_n       <= 1'b1;
            r_enc_done        <= 1'b0;
            r_rgb_addr        <= RGB_BASE;
            r_y_addr          <= Y_BASE;
            r_u_addr          <= U_BASE;
            r_v_addr          <= V_BASE;
            r_group           <= '0;
        end else begin
            r_sram_address    <= w_sram_address;
            r_sram_write_data <= w_sram_write_data;
            r_sram_we_n       <= w_sram_we_n;
            r_enc_done        <= w_enc_done;
            r_rgb_addr        <= w_rgb_addr;
            r_y_addr          <= w_y_addr;
            r_u_addr          <= w_u_addr;
            r_v_addr          <= w_v_addr;
            r_group           <= w_group;
        end
    end

    // Capture read words two cycles after their address was driven
    always_ff @(posedge CLOCK_50_I) begin
        case (r_state)
            S_RD2:   r_word[0] <= SRAM_read_data;
            S_RD3:   r_word[1] <= SRAM_read_data;
            S_RD4:   r_word[2] <= SRAM_read_data;
            S_RD5:   r_word[3] <= SRAM_read_data;
            S_WAIT0: r_word[4] <= SRAM_read_data;
            S_WAIT1: r_word[5] <= SRAM_read_data;
            default: ;
        endcase
    end

    // Hold the converted bytes of each half-group until they are written
    always_ff @(posedge CLOCK_50_I) begin
        if (r_state == S_CALC0) begin
            r_y0  <= w_y_a;
            r_y1  <= w_y_b;
            r_u01 <= w_u;
            r_v01 <= w_v;
        end
        if (r_state == S_CALC1) begin
            r_y2  <= w_y_a;
            r_y3  <= w_y_b;
            r_u23 <= w_u;
            r_v23 <= w_v;
        end
    end

endmodule

// File: tb/tb_rgb_downsampler.sv
// tb/tb_rgb_downsampler.sv - directed bench for rgb_downsampler with a 2-cycle-latency SRAM model
module tb_rgb_downsampler;

    localparam int          N     = 8;
    localparam logic [17:0] RGB_B = 18'd146944;
    localparam logic [17:0] Y_B   = 18'd0;
    localparam logic [17:0] U_B   = 18'd38400;
    localparam logic [17:0] V_B   = 18'd57600;
    localparam int          NPAT  = 7;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enc_start = 1'b0;
    logic [17:0] sram_address;
    logic [15:0] sram_write_data;
    logic        sram_we_n;
    logic [15:0] sram_read_data;
    logic        enc_done;

    logic [17:0] rd_p1 = 18'd0;
    logic [17:0] rd_p2 = 18'd0;
    int          cur_pat = 0;
    int          cur_rot = 0;

    int n_checks = 0;
    int n_errs   = 0;

    rgb_downsampler #(
        .RGB_BASE  (RGB_B),
        .Y_BASE    (Y_B),
        .U_BASE    (U_B),
        .V_BASE    (V_B),
        .NUM_GROUPS(N)
    ) dut (
        .CLOCK_50_I     (clk),
        .Resetn         (resetn),
        .SRAM_address   (sram_address),
        .SRAM_write_data(sram_write_data),
        .SRAM_we_n      (sram_we_n),
        .SRAM_read_data (sram_read_data),
        .enc_start      (enc_start),
        .enc_done       (enc_done)
    );

    always #5 clk = ~clk;

    // 0 white, 1 black, 2 red, 3 white/black/white/white, 4 blue, 5 green, 6 red pair + blue pair
    function automatic logic [15:0] pat_word(input int p, input int i);
        logic [15:0] t [6];
        case (p)
            0: t = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
            1: t = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
            2: t = '{16'hFF00, 16'h00FF, 16'h0000, 16'hFF00, 16'h00FF, 16'h0000};
            3: t = '{16'hFFFF, 16'hFF00, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
            4: t = '{16'h0000, 16'hFF00, 16'h00FF, 16'h0000, 16'hFF00, 16'h00FF};
            5: t = '{16'h00FF, 16'h0000, 16'hFF00, 16'h00FF, 16'h0000, 16'hFF00};
            default: t = '{16'hFF00, 16'h00FF, 16'h0000, 16'h0000, 16'hFF00, 16'h00FF};
        endcase
        return t[i];
    endfunction

    // Hand-computed outputs: {Y0,Y1}, {Y2,Y3}, {U01,U23}, {V01,V23}
    function automatic logic [15:0] pat_exp(input int p, input int i);
        logic [15:0] t [4];
        case (p)
            0: t = '{16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080};
            1: t = '{16'h1010, 16'h1010, 16'h8080, 16'h8080};
            2: t = '{16'h5252, 16'h5252, 16'h5A5A, 16'hF0F0};
            3: t = '{16'hEB10, 16'hEBEB, 16'h8080, 16'h8080};
            4: t = '{16'h2929, 16'h2929, 16'hF0F0, 16'h6E6E};
            5: t = '{16'h9191, 16'h9191, 16'h3636, 16'h2222};
            default: t = '{16'h5252, 16'h2929, 16'h5AF0, 16'hF06E};
        endcase
        return t[i];
    endfunction

    function automatic int group_pat(input int g, input int pat, input int rot);
        return (rot != 0) ? (pat + g) % NPAT : pat;
    endfunction

    function automatic logic [15:0] img_word(input logic [17:0] a, input int pat, input int rot);
        int off;
        off = int'(a) - int'(RGB_B);
        if (off < 0 || off >= 6 * N)
            return 16'h0BAD;
        return pat_word(group_pat(off / 6, pat, rot), off % 6);
    endfunction

    // SRAM read path: data for the address of cycle c is on the bus during cycle c+2
    always @(posedge clk) begin
        rd_p1 <= sram_address;
        rd_p2 <= rd_p1;
    end
    assign sram_read_data = img_word(rd_p2, cur_pat, cur_rot);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_image(input int pat, input int rot, input int hold);
        int bad_we, bad_addr, bad_data, bad_done, writes;
        int g, c, ea;
        bad_we = 0; bad_addr = 0; bad_data = 0; bad_done = 0; writes = 0;
        cur_pat = pat;
        cur_rot = rot;
        @(negedge clk);
        enc_start = 1'b1;
        @(negedge clk);
        if (hold == 0)
            enc_start = 1'b0;
        for (int k = 0; k < 14 * N; k++) begin
            g = k / 14;
            c = k % 14;
            if (hold != 0 && k == 20) enc_start = 1'b0;
            if (hold != 0 && k == 22) enc_start = 1'b1;
            if (k == 0)  chk("first_rd_addr", 32'(sram_address), 32'(RGB_B));
            if (k == 10) chk("first_y_addr", 32'(sram_address), 32'(Y_B));
            if (k == 12) chk("first_u_addr", 32'(sram_address), 32'(U_B));
            if (k == 13) chk("first_v_addr", 32'(sram_address), 32'(V_B));
            if (sram_we_n !== ((c >= 10) ? 1'b0 : 1'b1)) bad_we++;
            if (sram_we_n === 1'b0) writes++;
            if (enc_done !== 1'b0) bad_done++;
            if (c < 6) begin
                if (int'(sram_address) != int'(RGB_B) + 6 * g + c) bad_addr++;
            end else if (c >= 10) begin
                case (c)
                    10:      ea = int'(Y_B) + 2 * g;
                    11:      ea = int'(Y_B) + 2 * g + 1;
                    12:      ea = int'(U_B) + g;
                    default: ea = int'(V_B) + g;
                endcase
                if (int'(sram_address) != ea) bad_addr++;
                if (sram_write_data !== pat_exp(group_pat(g, pat, rot), c - 10)) begin
                    bad_data++;
                    if (bad_data <= 3)
                        $display("  write g=%0d c=%0d data=%h want=%h", g, c,
                                 sram_write_data, pat_exp(group_pat(g, pat, rot), c - 10));
                end
            end
            @(negedge clk);
        end
        chk("done_pulse", 32'(enc_done), 32'd1);
        chk("done_we_n", 32'(sram_we_n), 32'd1);
        enc_start = 1'b0;
        @(negedge clk);
        chk("done_clear", 32'(enc_done), 32'd0);
        chk("idle_we_n", 32'(sram_we_n), 32'd1);
        chk("we_n_pattern", 32'(bad_we), 32'd0);
        chk("addr_sequence", 32'(bad_addr), 32'd0);
        chk("write_data", 32'(bad_data), 32'd0);
        chk("done_early", 32'(bad_done), 32'd0);
        chk("write_count", 32'(writes), 32'(4 * N));
    endtask

    initial begin
        resetn = 1'b0;
        enc_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(sram_address), 32'd0);
        chk("rst_wdata", 32'(sram_write_data), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_done", 32'(enc_done), 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_no_start", 32'(sram_we_n), 32'd1);
        chk("idle_addr", 32'(sram_address), 32'd0);

        run_image(0, 0, 0);
        run_image(1, 0, 0);
        run_image(2, 0, 0);
        run_image(3, 0, 0);
        run_image(0, 1, 0);
        run_image(6, 1, 1);

        cur_pat = 0;
        cur_rot = 1;
        @(negedge clk);
        enc_start = 1'b1;
        @(negedge clk);
        enc_start = 1'b0;
        repeat (81) @(negedge clk);
        chk("pre_rst_write", 32'(sram_we_n), 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_we_n", 32'(sram_we_n), 32'd1);
        chk("midrst_done", 32'(enc_done), 32'd0);
        chk("midrst_addr", 32'(sram_address), 32'd0);
        chk("midrst_wdata", 32'(sram_write_data), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(sram_we_n), 32'd1);
        run_image(2, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
